ir_key_event_ctrl: RTL

//  Sequences raw key frames from the NEC IR decoder (done pulse + 8-bit key) into a

---
 rtl/ir_pkg.sv | 64 ++++++
 rtl/ir_evt_fifo.sv | 63 ++++++
 rtl/ir_key_event_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR key event controller: event codes,
// hold-tracker states, event payload and the remote's key-map ROM contents.
package ir_pkg;

    localparam int unsigned KEY_W  = 8;
    localparam int unsigned TYPE_W = 2;
    localparam int unsigned IDX_W  = 5;

    localparam logic [TYPE_W-1:0] EVT_NONE    = 2'b00;
    localparam logic [TYPE_W-1:0] EVT_PRESS   = 2'b01;
    localparam logic [TYPE_W-1:0] EVT_REPEAT  = 2'b10;
    localparam logic [TYPE_W-1:0] EVT_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [KEY_W-1:0]  code;
    } evt_t;

    // Key-map indices for the 21-button remote, in NEC code order below
    localparam logic [IDX_W-1:0] KEY_CH_DN  = 5'd0,  KEY_CH     = 5'd1,  KEY_CH_UP  = 5'd2;
    localparam logic [IDX_W-1:0] KEY_PREV   = 5'd3,  KEY_NEXT   = 5'd4,  KEY_PLAY   = 5'd5;
    localparam logic [IDX_W-1:0] KEY_VOL_DN = 5'd6,  KEY_VOL_UP = 5'd7,  KEY_EQ     = 5'd8;
    localparam logic [IDX_W-1:0] KEY_0      = 5'd9,  KEY_100    = 5'd10, KEY_200    = 5'd11;
    localparam logic [IDX_W-1:0] KEY_1      = 5'd12, KEY_2      = 5'd13, KEY_3      = 5'd14;
    localparam logic [IDX_W-1:0] KEY_4      = 5'd15, KEY_5      = 5'd16, KEY_6      = 5'd17;
    localparam logic [IDX_W-1:0] KEY_7      = 5'd18, KEY_8      = 5'd19, KEY_9      = 5'd20;
    localparam logic [IDX_W-1:0] KEY_UNMAPPED = 5'd31;

    function automatic logic [IDX_W-1:0] key_map(input logic [KEY_W-1:0] code);
        logic [IDX_W-1:0] idx;
        case (code)
            8'h45: idx = KEY_CH_DN;
            8'h46: idx = KEY_CH;
            8'h47: idx = KEY_CH_UP;
            8'h44: idx = KEY_PREV;
            8'h40: idx = KEY_NEXT;
            8'h43: idx = KEY_PLAY;
            8'h07: idx = KEY_VOL_DN;
            8'h15: idx = KEY_VOL_UP;
            8'h09: idx = KEY_EQ;
            8'h16: idx = KEY_0;
            8'h19: idx = KEY_100;
            8'h0D: idx = KEY_200;
            8'h0C: idx = KEY_1;
            8'h18: idx = KEY_2;
            8'h5E: idx = KEY_3;
            8'h08: idx = KEY_4;
            8'h1C: idx = KEY_5;
            8'h5A: idx = KEY_6;
            8'h42: idx = KEY_7;
            8'h52: idx = KEY_8;
            8'h4A: idx = KEY_9;
            default: idx = KEY_UNMAPPED;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Synchronous event FIFO (DEPTH x evt_t); push on full is accepted only
// when a pop happens in the same cycle, pop on empty is ignored.
module ir_evt_fifo
    import ir_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  evt_t                   din,
    output evt_t                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    evt_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/ir_key_event_ctrl.sv
// Turns NEC decoder key frames into PRESS/REPEAT/RELEASE events behind a FIFO.
// IR_KEYMAP_EN: map NEC codes to remote indices (one extra cycle, unmapped frames dropped).
module ir_key_event_ctrl
    import ir_pkg::*;
#(
    parameter int unsigned HOLD_CYC   = 6_000_000,
    parameter int unsigned REP_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_type,
    output logic [7:0] cmd_code,
    input  logic       ovf_clr,
    output logic       ovf
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int unsigned REP_W  = 4;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic             frame_vld;
    logic [KEY_W-1:0] frame_key;

`ifdef IR_KEYMAP_EN
    logic             map_vld_q, map_vld_d;
    logic [IDX_W-1:0] map_idx_q, map_idx_d;

    // Registered ROM lookup; unmapped codes never reach the hold tracker
    always_comb begin
        map_idx_d = key_map(key);
        map_vld_d = key_valid && (map_idx_d != KEY_UNMAPPED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_vld_q <= 1'b0;
            map_idx_q <= '0;
        end else begin
            map_vld_q <= map_vld_d;
            map_idx_q <= map_idx_d;
        end
    end

    always_comb begin
        frame_vld = map_vld_q;
        frame_key = KEY_W'(map_idx_q);
    end
`else
    always_comb begin
        frame_vld = key_valid;
        frame_key = key;
    end
`endif

    state_e           state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [KEY_W-1:0] last_key_q, last_key_d;
    logic             push_q, push_d;
    evt_t             push_evt_q, push_evt_d;
    logic             ovf_q, ovf_d;

    evt_t             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             pop_acc;
    logic             drop;

    // Hold tracker: a frame beats a simultaneous timeout
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        last_key_d = last_key_q;
        push_d     = 1'b0;
        push_evt_d = push_evt_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_vld) begin
                    push_d          = 1'b1;
                    push_evt_d.typ  = EVT_PRESS;
                    push_evt_d.code = frame_key;
                    last_key_d      = frame_key;
                    hold_cnt_d      = '0;
                    rep_cnt_d       = '0;
                    state_d         = ST_HELD;
                end
            end
            ST_HELD: begin
                if (hold_cnt_q != HOLD_W'(HOLD_CYC)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (frame_vld && (frame_key == last_key_q)) begin
                    hold_cnt_d = '0;
                    if (rep_cnt_q == REP_W'(REP_DIV - 1)) begin
                        push_d          = 1'b1;
                        push_evt_d.typ  = EVT_REPEAT;
                        push_evt_d.code = last_key_q;
                        rep_cnt_d       = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end else if (frame_vld) begin
                    push_d          = 1'b1;
                    push_evt_d.typ  = EVT_RELEASE;
                    push_evt_d.code = last_key_q;
                    last_key_d      = frame_key;
                    state_d         = ST_SWITCH;
                end else if (hold_cnt_q == HOLD_W'(HOLD_CYC - 1)) begin
                    push_d          = 1'b1;
                    push_evt_d.typ  = EVT_RELEASE;
                    push_evt_d.code = last_key_q;
                    state_d         = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                push_d          = 1'b1;
                push_evt_d.typ  = EVT_PRESS;
                push_evt_d.code = last_key_q;
                hold_cnt_d      = '0;
                rep_cnt_d       = '0;
                state_d         = ST_HELD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Overflow is sticky; a new drop wins over a clear in the same cycle
    always_comb begin
        pop_acc = cmd_ready && (fifo_count != '0);
        drop    = push_q && fifo_full && !pop_acc;
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            last_key_q <= '0;
            push_q     <= 1'b0;
            push_evt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            last_key_q <= last_key_d;
            push_q     <= push_d;
            push_evt_q <= push_evt_d;
            ovf_q      <= ovf_d;
        end
    end

    ir_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (cmd_ready),
        .din   (push_evt_q),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_valid = !fifo_empty;
    assign cmd_type  = fifo_head.typ;
    assign cmd_code  = fifo_head.code;
    assign ovf       = ovf_q;

endmodule
